sub_mod_serial: RTL

- Word-serial modular subtractor: y = (a - b) mod m, for operands a, b < m.
- Computes the raw difference as a WBITS-wide borrow chain over NBITS/WBITS cycles.
- If the raw difference underflows, a second serial pass adds m back.
- Companion to the adder blocks. Feeds Montgomery datapaths where area matters more than latency.

---
 rtl/sub_mod_serial.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sub_mod_serial.sv
// Word-serial modular subtractor: y = (a - b) mod m.
// The raw difference is formed one WBITS-wide word per cycle, LSW first, via a
// borrow chain. If the full difference underflows, a second serial pass adds m
// back. A single WBITS+1-bit adder serves both passes: in the subtract pass the
// subtrahend word is inverted and the borrow is carried as an inverted carry.
module sub_mod_serial #(
    parameter int NBITS = 256,
    parameter int WBITS = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    input  logic [NBITS-1:0] m,
    output logic             busy,
    output logic             done,
    output logic             bout,
    output logic [NBITS-1:0] y
);

    localparam int NWORDS = NBITS / WBITS;
    localparam int IDXW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    // Handshake: start is sampled on a rising edge only while idle; busy is
    // high from the cycle after the accept through the done cycle; done is a
    // one-cycle pulse with y/bout valid from that cycle and held until the
    // next done. Requests arriving while busy are dropped, not queued.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_CORR = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [NBITS-1:0]  a_q, a_d;
    logic [NBITS-1:0]  b_q, b_d;
    logic [NBITS-1:0]  m_q, m_d;
    logic [NBITS-1:0]  r_q, r_d;
    logic              cy_q, cy_d;     // borrow in SUB, carry in CORR
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [NBITS-1:0]  y_q, y_d;
    logic              bout_q, bout_d;

    logic [WBITS-1:0]  op_x;
    logic [WBITS-1:0]  op_z;
    logic              op_c;
    logic [WBITS:0]    sum;
    logic              last_word;

    // Shared word adder; subtraction uses a + ~b + ~borrow, so carry-out = ~borrow.
    always_comb begin
        op_x = r_q[WBITS-1:0];
        op_z = m_q[WBITS-1:0];
        op_c = cy_q;
        if (state_q == S_SUB) begin
            op_x = a_q[WBITS-1:0];
            op_z = ~b_q[WBITS-1:0];
            op_c = ~cy_q;
        end
        sum       = {1'b0, op_x} + {1'b0, op_z} + {{WBITS{1'b0}}, op_c};
        last_word = (idx_q == IDXW'(NWORDS - 1));
    end

    // Next-state and datapath update for the IDLE/SUB/CORR/DONE sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        r_d     = r_q;
        cy_d    = cy_q;
        idx_d   = idx_q;
        y_d     = y_q;
        bout_d  = bout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    m_d     = m;
                    cy_d    = 1'b0;
                    idx_d   = '0;
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                // Result words shift in from the top so the LSW ends at bit 0.
                r_d   = {sum[WBITS-1:0], r_q[NBITS-1:WBITS]};
                a_d   = a_q >> WBITS;
                b_d   = b_q >> WBITS;
                cy_d  = ~sum[WBITS];
                idx_d = idx_q + 1'b1;
                if (last_word) begin
                    idx_d = '0;
                    if (~sum[WBITS]) begin
                        cy_d    = 1'b0;
                        state_d = S_CORR;
                    end else begin
                        y_d     = r_d;
                        bout_d  = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_CORR: begin
                // Add m back; the final carry-out wraps mod 2^NBITS.
                r_d   = {sum[WBITS-1:0], r_q[NBITS-1:WBITS]};
                m_d   = m_q >> WBITS;
                cy_d  = sum[WBITS];
                idx_d = idx_q + 1'b1;
                if (last_word) begin
                    idx_d   = '0;
                    y_d     = r_d;
                    bout_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            r_q     <= '0;
            cy_q    <= 1'b0;
            idx_q   <= '0;
            y_q     <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            r_q     <= r_d;
            cy_q    <= cy_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
            bout_q  <= bout_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign bout = bout_q;
    assign y    = y_q;

endmodule
